// File: rtl/fridge_pkg.sv
// Shared definitions for the fridge/freezer setpoint store and its readers.
package fridge_pkg;

   // Channel selectors, shared with the setpoint writer
   localparam logic [1:0] CH_FG_TEMP = 2'd0;
   localparam logic [1:0] CH_FR_TEMP = 2'd1;
   localparam logic [1:0] CH_FG_CAP  = 2'd2;
   localparam logic [1:0] CH_FR_CAP  = 2'd3;

   localparam int VAL_W      = 5;
   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 10;

   // Frame serialiser states
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   // One atomic copy of everything the reader reports
   typedef struct packed {
      logic [VAL_W-1:0] fgt;
      logic [VAL_W-1:0] frt;
      logic [VAL_W-1:0] fgc;
      logic [VAL_W-1:0] frc;
      logic             fgp;
      logic             frp;
   } snap_t;

   // Data byte for one channel: {ch, power flag, value}.
   // ch[1] selects capacity, ch[0] selects the freezer side.
   function automatic logic [DATA_W-1:0] mk_word(input logic [1:0] ch, input snap_t s);
      logic [VAL_W-1:0] v;
      logic             p;
      case (ch)
         CH_FG_TEMP: v = s.fgt;
         CH_FR_TEMP: v = s.frt;
         CH_FG_CAP:  v = s.fgc;
         default:    v = s.frc;
      endcase
      p = ch[0] ? s.frp : s.fgp;
      return {ch, p, v};
   endfunction

endpackage

// File: rtl/fridge_frame_tx.sv
// Serialises one 8-bit word as a start/8 data LSB-first/stop frame.
// A load pulse wins over everything, so a follow-on frame can start in the
// cycle right after frame_done with no idle bit between frames.
module fridge_frame_tx
   import fridge_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              tx,
   output logic              frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [3:0]              bit_q, bit_d;
   logic [FRAME_BITS-1:0]   sr_q, sr_d;
   logic                    last;

   // The line is the shift register LSB; all-ones means idle high
   assign tx         = sr_q[0];
   assign last       = (cnt_q == CNT_MAX);
   assign frame_done = (state_q == TX_STOP) && last;

   // Next-state: bit timer, bit index and shifter advance on terminal count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      if (load) begin
         state_d = TX_START;
         cnt_d   = '0;
         bit_d   = '0;
         sr_d    = {1'b1, data, 1'b0};
      end else if (state_q != TX_IDLE) begin
         if (!last) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = '0;
            sr_d  = {1'b1, sr_q[FRAME_BITS-1:1]};
            case (state_q)
               TX_START: begin
                  state_d = TX_DATA;
                  bit_d   = bit_q + 4'd1;
               end
               TX_DATA: begin
                  bit_d = bit_q + 4'd1;
                  if (bit_q == 4'd8) state_d = TX_STOP;
               end
               TX_STOP: begin
                  state_d = TX_IDLE;
                  bit_d   = '0;
               end
               default: state_d = TX_IDLE;
            endcase
         end
      end
   end

   // State registers; reset returns the line high at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
      end
   end

endmodule

// File: rtl/fridge_status_reader.sv
// Snapshots the setpoint store and streams one or all four channels as
// framed serial words. The first word is built straight from the live
// inputs so its start bit can leave in the cycle after the accept.
module fridge_status_reader
   import fridge_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] fgt,
   input  logic [4:0] frt,
   input  logic [4:0] fgc,
   input  logic [4:0] frc,
   input  logic       fgp,
   input  logic       frp,
   input  logic       rd_req,
   input  logic       rd_all,
   input  logic [1:0] rd_sel,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   snap_t             snap_q, snap_d, live;
   logic              all_q, all_d;
   logic [1:0]        ch_q, ch_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load;
   logic [DATA_W-1:0] word;
   logic              frame_done;

   assign live = {fgt, frt, fgc, frc, fgp, frp};
   assign busy = busy_q;
   assign done = done_q;

   // Accept in idle, then step through channels until the last frame ends
   always_comb begin
      snap_d = snap_q;
      all_d  = all_q;
      ch_d   = ch_q;
      busy_d = busy_q;
      done_d = 1'b0;
      load   = 1'b0;
      word   = '0;
      if (!busy_q && rd_req) begin
         snap_d = live;
         all_d  = rd_all;
         ch_d   = rd_all ? CH_FG_TEMP : rd_sel;
         busy_d = 1'b1;
         load   = 1'b1;
         word   = mk_word(rd_all ? CH_FG_TEMP : rd_sel, live);
      end else if (busy_q && frame_done) begin
         if (all_q && (ch_q != CH_FR_CAP)) begin
            ch_d = ch_q + 2'd1;
            load = 1'b1;
            word = mk_word(ch_q + 2'd1, snap_q);
         end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Snapshot, sequencing and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q <= '0;
         all_q  <= 1'b0;
         ch_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         snap_q <= snap_d;
         all_q  <= all_d;
         ch_q   <= ch_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   fridge_frame_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_frame_tx (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .data       (word),
      .tx         (tx),
      .frame_done (frame_done)
   );

endmodule
